// File: rtl/rc4_decrypt_core.sv
// RC4 PRGA decryptor: XORs the keystream from an external S-RAM with MSG_LEN ROM bytes.
// 12 cycles per byte; decrypt_done rises 12*MSG_LEN+1 edges after start, no flow control.
module rc4_decrypt_core #(
    parameter int MSG_LEN = 32
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [4:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [7:0] decrypted_data [0:31],
    output logic       decrypt_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        READ_SI,
        WAIT_SI,
        LATCH_SI,
        READ_SJ,
        WAIT_SJ,
        LATCH_SJ,
        WRITE_SI,
        WRITE_SJ,
        READ_F,
        WAIT_F,
        XOR,
        NEXT,
        DONE
    } state_t;

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    state_t     state;
    logic [7:0] i;
    logic [7:0] j;
    logic [4:0] k;
    logic [7:0] si;
    logic [7:0] sj;

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            si           <= '0;
            sj           <= '0;
            s_address    <= '0;
            s_data       <= '0;
            s_wren       <= 1'b0;
            rom_address  <= '0;
            decrypt_done <= 1'b0;
            busy         <= 1'b0;
            for (int n = 0; n < 32; n++) decrypted_data[n] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= INIT;
                        busy         <= 1'b1;
                        decrypt_done <= 1'b0;
                        for (int n = 0; n < 32; n++) decrypted_data[n] <= '0;
                    end
                end
                INIT: begin
                    i         <= 8'd1;
                    j         <= 8'd0;
                    k         <= 5'd0;
                    s_address <= 8'd1;
                    state     <= READ_SI;
                    for (int n = 0; n < 32; n++) decrypted_data[n] <= '0;
                end
                READ_SI:  state <= WAIT_SI;
                WAIT_SI:  state <= LATCH_SI;
                LATCH_SI: begin
                    si        <= s_q;
                    j         <= j + s_q;
                    s_address <= j + s_q;
                    state     <= READ_SJ;
                end
                READ_SJ:  state <= WAIT_SJ;
                WAIT_SJ:  state <= LATCH_SJ;
                LATCH_SJ: begin
                    sj        <= s_q;
                    s_address <= i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    state     <= WRITE_SI;
                end
                // When i == j both writes still happen and leave S unchanged.
                WRITE_SI: begin
                    s_address <= j;
                    s_data    <= si;
                    s_wren    <= 1'b1;
                    state     <= WRITE_SJ;
                end
                WRITE_SJ: begin
                    s_wren      <= 1'b0;
                    s_address   <= si + sj;
                    rom_address <= k;
                    state       <= READ_F;
                end
                READ_F: state <= WAIT_F;
                WAIT_F: state <= XOR;
                XOR: begin
                    decrypted_data[k] <= s_q ^ rom_q;
                    state             <= NEXT;
                end
                NEXT: begin
                    if (k == LAST_K) begin
                        busy         <= 1'b0;
                        decrypt_done <= 1'b1;
                        state        <= DONE;
                    end else begin
                        k         <= k + 5'd1;
                        i         <= i + 8'd1;
                        s_address <= i + 8'd1;
                        state     <= READ_SI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: behavioural S-RAM/ROM plus an array-based RC4 PRGA model.
module tb_rc4_decrypt_core;

    localparam int MSG_LEN = 32;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q = 8'd0;
    logic [4:0] rom_address;
    logic [7:0] rom_q = 8'd0;
    logic [7:0] decrypted_data [0:31];
    logic       decrypt_done;
    logic       busy;

    rc4_decrypt_core #(.MSG_LEN(MSG_LEN)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .start          (start),
        .s_address      (s_address),
        .s_data         (s_data),
        .s_wren         (s_wren),
        .s_q            (s_q),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .decrypted_data (decrypted_data),
        .decrypt_done   (decrypt_done),
        .busy           (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [32];
    int         ref_s   [256];
    int         exp_pt  [32];
    logic [15:0] exp_wr [$];
    logic [15:0] wr_log [$];
    bit         log_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    // Synchronous RAM/ROM, one-cycle read latency, read returns pre-write data.
    always @(posedge CLOCK_50) begin
        s_q   <= s_mem[s_address];
        rom_q <= rom_mem[rom_address];
        if (s_wren) s_mem[s_address] = s_data;
    end

    always @(negedge CLOCK_50) begin
        if (log_en && s_wren) wr_log.push_back({s_address, s_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nonzero_bytes();
        int c = 0;
        for (int n = 0; n < 32; n++) if (decrypted_data[n] != 8'd0) c++;
        return c;
    endfunction

    task automatic load_s(input bit random_s);
        for (int n = 0; n < 256; n++) begin
            s_mem[n] = random_s ? 8'($urandom_range(0, 255)) : 8'(n);
            ref_s[n] = int'(s_mem[n]);
        end
    endtask

    task automatic load_rom(input int mode);
        for (int n = 0; n < 32; n++)
            rom_mem[n] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    endtask

    // Plain RC4 PRGA over the model's copy of S; also lists the expected S writes.
    task automatic model_run();
        int i = 0;
        int j = 0;
        int t;
        exp_wr.delete();
        for (int n = 0; n < 32; n++) exp_pt[n] = 0;
        for (int n = 0; n < MSG_LEN; n++) begin
            i = (i + 1) % 256;
            j = (j + ref_s[i]) % 256;
            exp_wr.push_back({8'(i), 8'(ref_s[j])});
            exp_wr.push_back({8'(j), 8'(ref_s[i])});
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
            exp_pt[n] = ref_s[(ref_s[i] + ref_s[j]) % 256] ^ int'(rom_mem[n]);
        end
    endtask

    task automatic run(input string tag, input int pulse_at, output int edges);
        wr_log.delete();
        log_en = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        chk({tag, "_done_fall"}, decrypt_done, 0);
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_cleared"}, nonzero_bytes(), 0);
        edges = 0;
        while (edges < 2000) begin
            @(posedge CLOCK_50);
            edges++;
            #1;
            if (pulse_at != 0 && edges == pulse_at) start = 1'b1;
            if (pulse_at != 0 && edges == pulse_at + 1) start = 1'b0;
            if (decrypt_done) break;
        end
        log_en = 1'b0;
        chk({tag, "_latency"}, edges, 12 * MSG_LEN + 1);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    task automatic check_results(input string tag);
        int bad = 0;
        for (int n = 0; n < 32; n++)
            chk($sformatf("%s_b%0d", tag, n), decrypted_data[n], exp_pt[n]);
        chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        for (int n = 0; n < exp_wr.size() && n < wr_log.size(); n++)
            if (wr_log[n] !== exp_wr[n]) bad++;
        chk({tag, "_wr_seq_bad"}, bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(s_mem[n]) != ref_s[n]) bad++;
        chk({tag, "_s_final_bad"}, bad, 0);
    endtask

    initial begin
        int e;
        logic [15:0] w2;
        logic [15:0] w3;

        load_s(1'b0);
        load_rom(0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", decrypt_done, 0);
        chk("rst_wren", s_wren, 0);
        chk("rst_addr", s_address, 0);
        chk("rst_data", nonzero_bytes(), 0);
        reset = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("idle_busy", busy, 0);

        // Identity S, zero ROM: raw keystream
        model_run();
        run("A", 0, e);
        chk("A_byte0", decrypted_data[0], 8'h02);
        chk("A_byte1", decrypted_data[1], 8'h05);
        w2 = (wr_log.size() > 3) ? wr_log[2] : 16'h0;
        w3 = (wr_log.size() > 3) ? wr_log[3] : 16'h0;
        chk("A_wr_byte1_first", w2, 16'h0203);
        chk("A_wr_byte1_second", w3, 16'h0302);
        check_results("A");

        // Restart from DONE with the permuted S left by the previous run
        repeat (4) @(posedge CLOCK_50);
        #1;
        chk("A_done_held", decrypt_done, 1);
        load_rom(2);
        model_run();
        run("B", 0, e);
        check_results("B");

        load_s(1'b0);
        load_rom(1);
        model_run();
        run("C", 0, e);
        chk("C_byte0", decrypted_data[0], 8'hFD);
        chk("C_byte1", decrypted_data[1], 8'hFA);
        check_results("C");

        // Start pulse in the middle of byte 3 must be ignored
        load_s(1'b1);
        load_rom(2);
        model_run();
        run("D", 1 + 12 * 3 + 5, e);
        check_results("D");

        // Reset in the middle of byte 5
        load_s(1'b1);
        load_rom(2);
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (68) @(posedge CLOCK_50);
        #1;
        chk("E_busy_before_rst", busy, 1);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        chk("E_rst_busy", busy, 0);
        chk("E_rst_done", decrypt_done, 0);
        chk("E_rst_wren", s_wren, 0);
        chk("E_rst_addr", s_address, 0);
        chk("E_rst_sdata", s_data, 0);
        chk("E_rst_rom_addr", rom_address, 0);
        chk("E_rst_data", nonzero_bytes(), 0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("E_stays_idle", busy, 0);
        load_s(1'b0);
        load_rom(2);
        model_run();
        run("E", 0, e);
        check_results("E");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_core.md
RC4_DECRYPT_CORE -- requirements
Module: rc4_decrypt_core

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, number of message bytes decrypted (1..32).
REQ-002 SHALL have port CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  begin decryption; sampled only in IDLE and DONE.
REQ-005 SHALL have port s_address  out  8  S-RAM address.
REQ-006 SHALL have port s_data  out  8  S-RAM write data.
REQ-007 SHALL have port s_wren  out  1  S-RAM write enable.
REQ-008 SHALL have port s_q  in  8  S-RAM read data, valid one cycle after the address is sampled.
REQ-009 SHALL have port rom_address  out  5  encrypted-message ROM address.
REQ-010 SHALL have port rom_q  in  8  ROM read data, same one-cycle latency as s_q.
REQ-011 SHALL have port decrypted_data  out  8 x 32 array  plaintext bytes, index 0 = first byte.
REQ-012 SHALL have port decrypt_done  out  1  level, high only in state DONE.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE and DONE.

Function
REQ-014 SHALL implement the RC4 PRGA: per byte k: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; decrypted_data[k]=f XOR rom[k].
REQ-015 SHALL keep all 8-bit arithmetic (i, j, S[i]+S[j]) modulo 256, carries discarded.
REQ-016 SHALL use states IDLE, INIT, READ_SI, WAIT_SI, LATCH_SI, READ_SJ, WAIT_SJ, LATCH_SJ, WRITE_SI, WRITE_SJ, READ_F, WAIT_F, XOR, NEXT, DONE.
REQ-017 IDLE: start=1 -> INIT; else stay.
REQ-018 INIT: i<=1, j<=0, k<=0, all decrypted_data bytes <=0 -> READ_SI.
REQ-019 READ_SI: s_address=i; LATCH_SI: si<=s_q, j<=j+s_q.
REQ-020 READ_SJ: s_address=j (updated j); LATCH_SJ: sj<=s_q.
REQ-021 WRITE_SI: s_address=i, s_data=sj, s_wren=1; WRITE_SJ: s_address=j, s_data=si, s_wren=1.
REQ-022 READ_F: s_address=si+sj, rom_address=k.
REQ-023 XOR: decrypted_data[k]<=s_q XOR rom_q.
REQ-024 NEXT: k==MSG_LEN-1 -> DONE; else k<=k+1, i<=i+1 -> READ_SI.
REQ-025 WAIT_* states SHALL only hold addresses; s_wren SHALL be 0 in every state except WRITE_SI and WRITE_SJ.
REQ-026 When i==j both writes SHALL still occur; net S content is unchanged.
REQ-027 Each byte SHALL take exactly 12 cycles; decrypt_done SHALL rise 12*MSG_LEN+1 rising edges after the edge that samples start (385 for MSG_LEN=32).
REQ-028 DONE: decrypt_done=1, decrypted_data held stable; start=1 -> INIT (restart with current S contents); else stay.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 Bytes with index >= MSG_LEN SHALL remain 0.

Reset
REQ-031 On reset=1 at a rising edge: state<=IDLE; i, j, k, si, sj <=0; all decrypted_data <=0; decrypt_done=0, busy=0, s_wren=0.
REQ-032 Reset SHALL override start and any in-progress operation in the same edge; no S write SHALL occur in the cycle following a reset edge.

Verification
REQ-033 S[x]=x, ROM all 0x00, start pulse -> decrypted_data[0]=0x02, [1]=0x05; decrypt_done rises exactly 385 edges after start.
REQ-034 Same S, ROM all 0xFF -> decrypted_data[0]=0xFD, [1]=0xFA.
REQ-035 S[x]=x, byte 1 -> write cycles observed: address 2 data 3, then address 3 data 2 (s_wren=1 for exactly those 2 cycles in that byte).
REQ-036 reset asserted during byte 5 -> next cycle state IDLE, busy=0, decrypt_done=0, s_wren=0, all outputs 0; fresh start completes normally.
REQ-037 start pulsed at byte 3 while busy -> no restart, total latency unchanged at 385.
REQ-038 In DONE, start pulse -> decrypt_done falls next cycle, outputs cleared, rises again 385 edges later using the permuted S.
